// File: rtl/sofa_ccff_loader.sv
// Configuration-chain loader for a SOFA-style FPGA fabric: presets the fabric,
// then shifts one word per prog_clk pulse into NUM_CHAINS parallel ccff chains.
module sofa_ccff_loader #(
   parameter int NUM_CHAINS    = 12,
   parameter int LEN_W         = 16,
   parameter int PRESET_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [LEN_W-1:0]      cfg_len,
   input  logic                  abort,
   input  logic                  word_valid,
   input  logic [NUM_CHAINS-1:0] word_data,
   output logic                  word_ready,
   output logic [NUM_CHAINS-1:0] ccff_head,
   output logic                  prog_clk,
   output logic                  config_enable,
   output logic                  pReset,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PRESET   = 2'd1,
      SHIFT_LO = 2'd2,
      SHIFT_HI = 2'd3
   } state_t;

   localparam logic [7:0] PRESET_LAST = 8'(PRESET_CYCLES - 1);

   state_t                  state_r, state_s;
   logic [LEN_W-1:0]        len_r, len_s;
   logic [LEN_W-1:0]        cnt_r, cnt_s;
   logic [7:0]              pcnt_r, pcnt_s;
   logic [NUM_CHAINS-1:0]   head_s;
   logic                    pclk_s;
   logic                    cfg_en_s;
   logic                    prst_s;
   logic                    ready_s;
   logic                    busy_s;
   logic                    done_s;

   // Next-state and next-output logic; every output is computed here and registered below.
   always_comb begin
      state_s  = state_r;
      len_s    = len_r;
      cnt_s    = cnt_r;
      pcnt_s   = pcnt_r;
      head_s   = ccff_head;
      pclk_s   = 1'b0;
      cfg_en_s = config_enable;
      prst_s   = pReset;
      ready_s  = 1'b0;
      busy_s   = 1'b1;
      done_s   = 1'b0;

      if (abort && (state_r != IDLE)) begin
         state_s  = IDLE;
         head_s   = {NUM_CHAINS{1'b0}};
         cfg_en_s = 1'b0;
         prst_s   = 1'b0;
         busy_s   = 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               busy_s = 1'b0;
               if (start && !abort) begin
                  if (cfg_len != {LEN_W{1'b0}}) begin
                     len_s    = cfg_len;
                     cnt_s    = {LEN_W{1'b0}};
                     pcnt_s   = 8'd0;
                     state_s  = PRESET;
                     cfg_en_s = 1'b1;
                     prst_s   = 1'b1;
                     busy_s   = 1'b1;
                  end else begin
                     done_s = 1'b1;
                  end
               end else begin
                  state_s = IDLE;
               end
            end
            PRESET: begin
               if (pcnt_r == PRESET_LAST) begin
                  state_s = SHIFT_LO;
                  prst_s  = 1'b0;
                  ready_s = 1'b1;
               end else begin
                  pcnt_s = pcnt_r + 8'd1;
               end
            end
            SHIFT_LO: begin
               // Head changes only on a handshake, so it stays put through a stall.
               if (word_valid && word_ready) begin
                  state_s = SHIFT_HI;
                  head_s  = word_data;
                  pclk_s  = 1'b1;
                  cnt_s   = cnt_r + LEN_W'(1);
               end else begin
                  ready_s = 1'b1;
               end
            end
            SHIFT_HI: begin
               if (cnt_r < len_r) begin
                  state_s = SHIFT_LO;
                  ready_s = 1'b1;
               end else begin
                  state_s  = IDLE;
                  done_s   = 1'b1;
                  cfg_en_s = 1'b0;
                  busy_s   = 1'b0;
                  head_s   = {NUM_CHAINS{1'b0}};
               end
            end
            default: begin
               state_s  = IDLE;
               head_s   = {NUM_CHAINS{1'b0}};
               cfg_en_s = 1'b0;
               prst_s   = 1'b0;
               busy_s   = 1'b0;
            end
         endcase
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= IDLE;
         len_r         <= {LEN_W{1'b0}};
         cnt_r         <= {LEN_W{1'b0}};
         pcnt_r        <= 8'd0;
         ccff_head     <= {NUM_CHAINS{1'b0}};
         prog_clk      <= 1'b0;
         config_enable <= 1'b0;
         pReset        <= 1'b0;
         word_ready    <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         state_r       <= state_s;
         len_r         <= len_s;
         cnt_r         <= cnt_s;
         pcnt_r        <= pcnt_s;
         ccff_head     <= head_s;
         prog_clk      <= pclk_s;
         config_enable <= cfg_en_s;
         pReset        <= prst_s;
         word_ready    <= ready_s;
         busy          <= busy_s;
         done          <= done_s;
      end
   end

endmodule
